// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI4 burst bridge.
// Holds the AXI encodings the bridge drives, the state enums of the
// read and write engines, and the latched request record.
package axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Widest AXI id the request record can carry; the top slices it to ID_W.
    localparam int MAX_ID_W = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_RESP
    } wr_state_t;

    typedef struct packed {
        logic                wr;
        logic [1:0]          size;
        logic [31:0]         addr;
        logic [7:0]          len;
        logic [MAX_ID_W-1:0] id;
    } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : request vector, one bit per requester
//   en         : arbitration enable; no grant is issued while low
//   grant      : one-hot grant (all zero when nothing is granted)
//   valid      : a grant was issued this cycle
// The pointer names the highest-priority requester and moves to grant+1
// (mod N) after each grant; it holds when nothing is granted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // First pass searches from the pointer upward; the second pass takes the
    // lowest requester, which covers the wrap-around below the pointer.
    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        ptr_next = ptr_reg;
        for (int j = 0; j < N; j++) begin
            if (en && !valid && req[j] && (PTR_W'(j) >= ptr_reg)) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                ptr_next = (j == N - 1) ? '0 : PTR_W'(j + 1);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (en && !valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                ptr_next = (j == N - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/axi_burst_bridge.sv
// N-master sram-like to AXI4 bridge with independent read and write engines,
// each holding one outstanding INCR burst and arbitrated round-robin.
// A read to a line with a writeback in flight is held off until the write
// engine returns to idle.
// Ports:
//   aclk, aresetn           : clock, asynchronous active-low reset
//   m_*                     : per-master sram-like request/response ports
//   m_rdata, m_rlast        : shared read beat, qualified by m_data_ok
//   ar*/r*/aw*/w*/b*        : AXI4 master channels
module axi_burst_bridge
    import axi_bridge_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 4,
    parameter int LINE_OFF    = 5
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_MASTERS-1:0]       m_req,
    input  logic [NUM_MASTERS-1:0]       m_wr,
    input  logic [NUM_MASTERS-1:0][1:0]  m_size,
    input  logic [NUM_MASTERS-1:0][31:0] m_addr,
    input  logic [NUM_MASTERS-1:0][7:0]  m_len,
    input  logic [NUM_MASTERS-1:0][31:0] m_wdata,
    input  logic [NUM_MASTERS-1:0][3:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]       m_addr_ok,
    output logic [NUM_MASTERS-1:0]       m_wnext,
    output logic [NUM_MASTERS-1:0]       m_data_ok,
    output logic [31:0]                  m_rdata,
    output logic                         m_rlast,
    output logic [ID_W-1:0]              arid,
    output logic [31:0]                  araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic [1:0]                   arlock,
    output logic [3:0]                   arcache,
    output logic [2:0]                   arprot,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [ID_W-1:0]              rid,
    input  logic [31:0]                  rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [ID_W-1:0]              awid,
    output logic [31:0]                  awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic [1:0]                   awlock,
    output logic [3:0]                   awcache,
    output logic [2:0]                   awprot,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ID_W-1:0]              wid,
    output logic [31:0]                  wdata,
    output logic [3:0]                   wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [ID_W-1:0]              bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int M = NUM_MASTERS;

    rd_state_t    rd_state_reg, rd_state_next;
    wr_state_t    wr_state_reg, wr_state_next;
    req_t         rd_req_reg, wr_req_reg, rd_sel, wr_sel;
    logic [M-1:0] rd_cand, wr_cand, rd_grant, wr_grant;
    logic         rd_valid, wr_valid, rd_en, wr_en;
    logic         aw_done_reg, w_done_reg, aw_hs, w_hs;
    logic [7:0]   beat_cnt_reg;

    // Response ids and codes are not used: routing follows the latched id.
    logic unused_in;
    assign unused_in = ^{rid, rresp, bid, bresp, rd_req_reg, wr_req_reg, RESP_OKAY};

    // Gating with aresetn keeps m_addr_ok at zero while reset is asserted.
    assign rd_en = aresetn && (rd_state_reg == R_IDLE);
    assign wr_en = aresetn && (wr_state_reg == W_IDLE);

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_master
            assign rd_cand[gi] = m_req[gi] && !m_wr[gi] &&
                !((wr_state_reg != W_IDLE) &&
                  (m_addr[gi][31:LINE_OFF] == wr_req_reg.addr[31:LINE_OFF]));
            assign wr_cand[gi] = m_req[gi] && m_wr[gi];
            assign m_data_ok[gi] =
                ((rd_state_reg == R_DATA) && rvalid && (rd_req_reg.id == MAX_ID_W'(gi))) ||
                ((wr_state_reg == W_RESP) && bvalid && (wr_req_reg.id == MAX_ID_W'(gi)));
            assign m_wnext[gi] = w_hs && (wr_req_reg.id == MAX_ID_W'(gi));
        end
    endgenerate

    rr_arbiter #(.N(M)) u_rd_arb (
        .clk(aclk), .rst_n(aresetn), .req(rd_cand), .en(rd_en),
        .grant(rd_grant), .valid(rd_valid)
    );

    rr_arbiter #(.N(M)) u_wr_arb (
        .clk(aclk), .rst_n(aresetn), .req(wr_cand), .en(wr_en),
        .grant(wr_grant), .valid(wr_valid)
    );

    assign m_addr_ok = rd_grant | wr_grant;

    // Request record of the granted master for each engine.
    always_comb begin
        rd_sel = '0;
        wr_sel = '0;
        for (int i = 0; i < M; i++) begin
            if (rd_grant[i]) rd_sel = '{wr: 1'b0, size: m_size[i], addr: m_addr[i],
                                        len: m_len[i], id: MAX_ID_W'(i)};
            if (wr_grant[i]) wr_sel = '{wr: 1'b1, size: m_size[i], addr: m_addr[i],
                                        len: m_len[i], id: MAX_ID_W'(i)};
        end
    end

    // ---------------- read engine ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_reg <= R_IDLE;
            rd_req_reg   <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            if (rd_valid) rd_req_reg <= rd_sel;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (rd_valid) rd_state_next = R_ADDR;
            R_ADDR:  if (arready) rd_state_next = R_DATA;
            R_DATA:  if (rvalid && rlast) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign arvalid = (rd_state_reg == R_ADDR);
    assign rready  = (rd_state_reg == R_DATA);
    assign arid    = rd_req_reg.id[ID_W-1:0];
    assign araddr  = rd_req_reg.addr;
    assign arlen   = rd_req_reg.len;
    assign arsize  = {1'b0, rd_req_reg.size};
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign m_rdata = (rd_state_reg == R_DATA) ? rdata : '0;
    assign m_rlast = (rd_state_reg == R_DATA) && rvalid && rlast;

    // ---------------- write engine ----------------
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_reg <= W_IDLE;
            wr_req_reg   <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            wr_state_reg <= wr_state_next;
            if (wr_valid) begin
                wr_req_reg   <= wr_sel;
                aw_done_reg  <= 1'b0;
                w_done_reg   <= 1'b0;
                beat_cnt_reg <= '0;
            end else if (wr_state_reg == W_XFER) begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs) begin
                    beat_cnt_reg <= beat_cnt_reg + 8'd1;
                    if (wlast) w_done_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE:  if (wr_valid) wr_state_next = W_XFER;
            W_XFER:  if ((aw_done_reg || aw_hs) && (w_done_reg || (w_hs && wlast)))
                         wr_state_next = W_RESP;
            W_RESP:  if (bvalid) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    // AW and W are raised together and each drops once its own part is done.
    assign awvalid = (wr_state_reg == W_XFER) && !aw_done_reg;
    assign wvalid  = (wr_state_reg == W_XFER) && !w_done_reg;
    assign wlast   = (wr_state_reg == W_XFER) && (beat_cnt_reg == wr_req_reg.len);
    assign bready  = (wr_state_reg == W_RESP);
    assign awid    = wr_req_reg.id[ID_W-1:0];
    assign wid     = wr_req_reg.id[ID_W-1:0];
    assign awaddr  = wr_req_reg.addr;
    assign awlen   = wr_req_reg.len;
    assign awsize  = {1'b0, wr_req_reg.size};
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    // Write beat comes straight from the granted master's port.
    always_comb begin
        wdata = '0;
        wstrb = '0;
        if (wr_state_reg == W_XFER) begin
            for (int i = 0; i < M; i++) begin
                if (wr_req_reg.id == MAX_ID_W'(i)) begin
                    wdata = m_wdata[i];
                    wstrb = m_wstrb[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_bridge.sv
module tb_axi_burst_bridge;

    localparam int M   = 2;
    localparam int IDW = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [M-1:0]      m_req, m_wr, m_addr_ok, m_wnext, m_data_ok;
    logic [M-1:0][1:0] m_size;
    logic [M-1:0][31:0] m_addr, m_wdata;
    logic [M-1:0][7:0] m_len;
    logic [M-1:0][3:0] m_wstrb;
    logic [31:0]       m_rdata;
    logic              m_rlast;
    logic [IDW-1:0]    arid, rid, awid, wid, bid;
    logic [31:0]       araddr, rdata, awaddr, wdata;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, arprot, awsize, awprot;
    logic [1:0]        arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0]        arcache, awcache, wstrb;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;

    axi_burst_bridge #(.NUM_MASTERS(M), .ID_W(IDW), .LINE_OFF(5)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_len(m_len),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_addr_ok(m_addr_ok), .m_wnext(m_wnext),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int nnext;
        int beat;
        logic [1:0] exp_g;

        m_req = 2'b11; m_wr = '0; m_size = '0; m_addr = '0; m_len = '0;
        m_wdata[0] = 32'h1111_1111; m_wdata[1] = 32'h2222_2222; m_wstrb = '1;
        arready = 1'b1; rid = '0; rdata = 32'hDEAD_BEEF; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_addr_ok", m_addr_ok, 2'b00);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arid", arid, 4'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_data_ok", m_data_ok, 2'b00);
        m_req = '0; rdata = '0;
        step;
        aresetn = 1'b1;
        step;

        // ---- 8-beat read by master 1 ----
        m_req = 2'b10; m_addr[1] = 32'h1FC0_0000; m_len[1] = 8'd7; m_size[1] = 2'd2;
        #1 chk("rd8_addr_ok", m_addr_ok, 2'b10);
        step;
        m_req = '0;
        #1;
        chk("rd8_arvalid", arvalid, 1'b1);
        chk("rd8_araddr", araddr, 32'h1FC0_0000);
        chk("rd8_arlen", arlen, 8'd7);
        chk("rd8_arid", arid, 4'd1);
        chk("rd8_arsize", arsize, 3'b010);
        chk("rd8_arburst", arburst, 2'b01);
        chk("rd8_no_early_ok", m_data_ok, 2'b00);
        step;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rdata = 32'hA500_0000 + k; rlast = (k == 7);
            #1;
            chk("rd8_data_ok", m_data_ok, 2'b10);
            chk("rd8_rdata", m_rdata, 32'hA500_0000 + k);
            chk("rd8_rlast", m_rlast, (k == 7));
            step;
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1 chk("rd8_idle_rready", rready, 1'b0);
        step;

        // ---- both masters reading: grants alternate 0,1,0,1 ----
        m_len = '0; m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            m_req = 2'b11;
            #1 chk("rr_addr_ok", m_addr_ok, exp_g);
            step;
            m_req = ~exp_g;
            #1;
            chk("rr_arvalid", arvalid, 1'b1);
            chk("rr_arid", arid, t % 2);
            chk("rr_busy_no_grant", m_addr_ok, 2'b00);
            step;
            rvalid = 1'b1; rlast = 1'b1; rdata = t;
            #1 chk("rr_data_ok", m_data_ok, exp_g);
            step;
            rvalid = 1'b0; rlast = 1'b0;
        end
        m_req = '0;
        step;

        // ---- 4-beat write by master 0, wready toggling ----
        m_req = 2'b01; m_wr = 2'b01; m_addr[0] = 32'h8000_0040; m_len[0] = 8'd3;
        m_size[0] = 2'd2; m_wdata[0] = 32'hC0DE_0000; awready = 1'b1; wready = 1'b0;
        #1 chk("wr4_addr_ok", m_addr_ok, 2'b01);
        step;
        m_req = '0;
        beat = 0; nnext = 0;
        for (int c = 1; c <= 8; c++) begin
            wready = (c % 2 == 0);
            m_wdata[0] = 32'hC0DE_0000 + beat;
            #1;
            if (c == 1) begin
                chk("wr4_awvalid", awvalid, 1'b1);
                chk("wr4_awaddr", awaddr, 32'h8000_0040);
                chk("wr4_awlen", awlen, 8'd3);
                chk("wr4_awid", awid, 4'd0);
            end
            if (c == 2) chk("wr4_aw_dropped", awvalid, 1'b0);
            chk("wr4_wvalid", wvalid, 1'b1);
            chk("wr4_wdata", wdata, 32'hC0DE_0000 + beat);
            chk("wr4_wlast", wlast, (beat == 3));
            chk("wr4_wnext", m_wnext, wready ? 2'b01 : 2'b00);
            if (m_wnext[0]) nnext++;
            step;
            awready = 1'b0;
            if (wready) beat++;
        end
        wready = 1'b0;
        #1;
        chk("wr4_wnext_count", nnext, 4);
        chk("wr4_wvalid_done", wvalid, 1'b0);
        chk("wr4_bready", bready, 1'b1);
        chk("wr4_no_early_ok", m_data_ok, 2'b00);
        step;
        bvalid = 1'b1;
        #1 chk("wr4_data_ok", m_data_ok, 2'b01);
        step;
        bvalid = 1'b0;
        #1 chk("wr4_bready_off", bready, 1'b0);
        step;

        // ---- read-after-write line hazard ----
        m_req = 2'b01; m_wr = 2'b01; m_addr[0] = 32'h8000_0040; m_len[0] = 8'd0;
        #1 chk("haz_wr_addr_ok", m_addr_ok, 2'b01);
        step;
        m_req = 2'b10; m_wr = 2'b00; m_addr[1] = 32'h8000_0048; m_len[1] = 8'd0;
        #1 chk("haz_block_1", m_addr_ok, 2'b00);
        step;
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("haz_block_2", m_addr_ok, 2'b00);
        chk("haz_wlast", wlast, 1'b1);
        step;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        chk("haz_wr_data_ok", m_data_ok, 2'b01);
        chk("haz_block_bvalid", m_addr_ok, 2'b00);
        step;
        bvalid = 1'b0;
        #1 chk("haz_release", m_addr_ok, 2'b10);
        step;
        m_req = '0;
        #1 chk("haz_araddr", araddr, 32'h8000_0048);
        step;
        rvalid = 1'b1; rlast = 1'b1;
        #1 chk("haz_rd_data_ok", m_data_ok, 2'b10);
        step;
        rvalid = 1'b0; rlast = 1'b0;

        // different line is granted while the write is outstanding
        m_req = 2'b01; m_wr = 2'b01; m_addr[0] = 32'h8000_0040;
        #1 chk("line_wr_addr_ok", m_addr_ok, 2'b01);
        step;
        m_req = 2'b10; m_wr = 2'b00; m_addr[1] = 32'h8000_0080;
        #1 chk("line_diff_grant", m_addr_ok, 2'b10);
        step;
        m_req = '0;
        #1 chk("line_arvalid", arvalid, 1'b1);
        step;
        rvalid = 1'b1; rlast = 1'b1;
        #1 chk("line_rd_data_ok", m_data_ok, 2'b10);
        step;
        rvalid = 1'b0; rlast = 1'b0; awready = 1'b1; wready = 1'b1;
        #1 chk("line_awvalid_held", awvalid, 1'b1);
        step;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1 chk("line_wr_data_ok", m_data_ok, 2'b01);
        step;
        bvalid = 1'b0;

        // ---- concurrent read and write grants ----
        m_req = 2'b11; m_wr = 2'b01; m_addr[0] = 32'h8000_0100; m_addr[1] = 32'h0000_1000;
        m_wdata[0] = 32'h5A5A_0001; awready = 1'b1; wready = 1'b1;
        #1 chk("conc_addr_ok", m_addr_ok, 2'b11);
        step;
        m_req = '0;
        #1;
        chk("conc_arvalid", arvalid, 1'b1);
        chk("conc_awvalid", awvalid, 1'b1);
        chk("conc_wvalid", wvalid, 1'b1);
        chk("conc_arid", arid, 4'd1);
        chk("conc_awid", awid, 4'd0);
        chk("conc_wdata", wdata, 32'h5A5A_0001);
        step;
        awready = 1'b0; wready = 1'b0; rvalid = 1'b1; rlast = 1'b1; bvalid = 1'b1;
        #1 chk("conc_data_ok", m_data_ok, 2'b11);
        step;
        rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0; m_wr = '0;

        // ---- reset during read beat 3 ----
        m_req = 2'b01; m_addr[0] = 32'h0000_2000; m_len[0] = 8'd7;
        #1 chk("rrst_addr_ok", m_addr_ok, 2'b01);
        step;
        m_req = '0;
        step;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rdata = 32'h55 + k;
            #1 chk("rrst_beat_ok", m_data_ok, 2'b01);
            step;
        end
        rdata = 32'h58; m_req = 2'b10; m_addr[1] = 32'h0000_3000; m_len[1] = 8'd0;
        #1 chk("rrst_beat3_ok", m_data_ok, 2'b01);
        aresetn = 1'b0;
        #1;
        chk("rrst_data_ok", m_data_ok, 2'b00);
        chk("rrst_m_rdata", m_rdata, 32'h0);
        chk("rrst_rready", rready, 1'b0);
        chk("rrst_araddr", araddr, 32'h0);
        chk("rrst_arlen", arlen, 8'h0);
        chk("rrst_addr_ok", m_addr_ok, 2'b00);
        step;
        rvalid = 1'b0;
        aresetn = 1'b1;
        #1 chk("post_rst_grant", m_addr_ok, 2'b10);
        step;
        m_req = '0;
        #1;
        chk("post_rst_arvalid", arvalid, 1'b1);
        chk("post_rst_araddr", araddr, 32'h0000_3000);
        chk("post_rst_arid", arid, 4'd1);
        step;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h77;
        #1;
        chk("post_rst_data_ok", m_data_ok, 2'b10);
        chk("post_rst_rdata", m_rdata, 32'h77);
        step;
        rvalid = 1'b0; rlast = 1'b0;
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
